alu_divu_seq: RTL and testbench

//  Multi-cycle 32-bit unsigned divider (restoring algorithm) for the EX stage. It has no subtractor
//  or comparator of its own. Each step is issued as an SLT or SUB op to the shared 32-bit ALU.

---
 rtl/alu_divu_seq_pkg.sv | 17 +
 rtl/alu_divu_seq.sv | 140 ++++++++++++++
 tb/tb_alu_divu_seq.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_divu_seq_pkg.sv
// Shared ALU signal codes and state encoding for the sequential unsigned divider.
package alu_divu_seq_pkg;

  localparam logic [2:0] SIG_ADD = 3'b010;
  localparam logic [2:0] SIG_SLT = 3'b111;

  localparam logic [5:0] DIV_STEPS = 6'd32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHIFT = 3'd1,
    ST_CMP   = 3'd2,
    ST_SUB   = 3'd3,
    ST_FIN   = 3'd4
  } state_e;

endpackage

// File: rtl/alu_divu_seq.sv
// Restoring 32-bit unsigned divider that borrows the shared EX-stage ALU for
// every compare and subtract through a req/gnt handshake.
module alu_divu_seq
  import alu_divu_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_by_zero,
  output logic        alu_req,
  input  logic        alu_gnt,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_signal,
  output logic        alu_inv,
  input  logic [31:0] alu_result
);

  state_e      state_q, state_d;
  logic [31:0] rem_q, rem_d;
  logic        rem_c_q, rem_c_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        dbz_q, dbz_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      rem_c_q <= 1'b0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      rem_c_q <= rem_c_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    rem_c_d    = rem_c_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    cnt_d      = cnt_q;
    dbz_d      = dbz_q;
    alu_req    = 1'b0;
    alu_a      = '0;
    alu_b      = '0;
    alu_signal = '0;
    alu_inv    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          quo_d   = dividend;
          rem_d   = '0;
          rem_c_d = 1'b0;
          dvs_d   = divisor;
          cnt_d   = DIV_STEPS;
          dbz_d   = 1'b0;
          if (divisor == '0) begin
            dbz_d   = 1'b1;
            quo_d   = '1;
            rem_d   = dividend;
            state_d = ST_FIN;
          end else begin
            state_d = ST_SHIFT;
          end
        end
      end

      // A carry out of the shift means the partial remainder already exceeds
      // any 32-bit divisor, so the compare can be skipped.
      ST_SHIFT: begin
        rem_c_d = rem_q[31];
        rem_d   = {rem_q[30:0], quo_q[31]};
        quo_d   = {quo_q[30:0], 1'b0};
        state_d = rem_q[31] ? ST_SUB : ST_CMP;
      end

      ST_CMP: begin
        alu_req    = 1'b1;
        alu_a      = rem_q;
        alu_b      = dvs_q;
        alu_signal = SIG_SLT;
        alu_inv    = 1'b1;
        if (alu_gnt) begin
          if (!rem_c_q && alu_result[0]) begin
            cnt_d   = cnt_q - 6'd1;
            state_d = (cnt_q == 6'd1) ? ST_FIN : ST_SHIFT;
          end else begin
            state_d = ST_SUB;
          end
        end
      end

      // The wrapped 32-bit difference is exact even when rem_c is set.
      ST_SUB: begin
        alu_req    = 1'b1;
        alu_a      = rem_q;
        alu_b      = dvs_q;
        alu_signal = SIG_ADD;
        alu_inv    = 1'b1;
        if (alu_gnt) begin
          rem_d   = alu_result;
          rem_c_d = 1'b0;
          quo_d   = {quo_q[31:1], 1'b1};
          cnt_d   = cnt_q - 6'd1;
          state_d = (cnt_q == 6'd1) ? ST_FIN : ST_SHIFT;
        end
      end

      ST_FIN: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_FIN);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_divu_seq.sv
// Self-checking bench: behavioural ALU behind the handshake, arithmetic reference model.
module tb_alu_divu_seq;
  import alu_divu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, alu_gnt;
  logic [31:0] dividend, divisor, alu_result;
  logic        busy, done, div_by_zero, alu_req, alu_inv;
  logic [31:0] quotient, remainder, alu_a, alu_b;
  logic [2:0]  alu_signal;

  int errors = 0;
  int checks = 0;
  int done_seen = 0;
  int idle_bad = 0;

  alu_divu_seq dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .alu_req(alu_req), .alu_gnt(alu_gnt),
    .alu_a(alu_a), .alu_b(alu_b), .alu_signal(alu_signal), .alu_inv(alu_inv),
    .alu_result(alu_result)
  );

  always #5 clk = ~clk;

  // Stand-in for the shared ALU
  always_comb begin
    alu_result = 32'd0;
    if (alu_signal == SIG_SLT && alu_inv) alu_result = {31'd0, (alu_a < alu_b)};
    else if (alu_signal == SIG_ADD && alu_inv) alu_result = alu_a - alu_b;
    else if (alu_signal == SIG_ADD) alu_result = alu_a + alu_b;
  end

  always @(posedge clk) if (done) done_seen++;

  // Cycles from the start cycle to the done cycle: per bit, 2 cycles when the
  // shifted remainder overflows or is below the divisor, 3 when compare then subtract.
  function automatic int model_cycles(input logic [31:0] a, input logic [31:0] b);
    longint unsigned r;
    int c;
    if (b == 32'd0) return 1;
    r = 0;
    c = 1;
    for (int i = 31; i >= 0; i--) begin
      r = (r << 1) | longint'(a[i]);
      if (r >= 64'h1_0000_0000) begin c += 2; r -= b; end
      else if (r >= b) begin c += 3; r -= b; end
      else c += 2;
    end
    return c;
  endfunction

  function automatic logic [31:0] model_q(input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
  endfunction

  function automatic logic [31:0] model_r(input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) ? a : a % b;
  endfunction

  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input bit rand_gnt,
                         output int cyc, output int denied);
    @(negedge clk);
    dividend = a; divisor = b; start = 1'b1; alu_gnt = 1'b1;
    @(negedge clk);
    start = 1'b0; dividend = $urandom; divisor = $urandom;
    cyc = 1; denied = 0;
    while (!done && cyc < 400) begin
      if (!alu_req && (alu_a != 0 || alu_b != 0 || alu_signal != 0 || alu_inv != 0)) idle_bad++;
      alu_gnt = rand_gnt ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (alu_req && !alu_gnt) denied++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; alu_gnt = 1'b0; dividend = 32'd55; divisor = 32'd5;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (quotient !== 32'd0 || remainder !== 32'd0 || div_by_zero !== 1'b0) begin
      errors++; $display("FAIL reset_results: got q=%0h r=%0h dbz=%b expected 0 0 0", quotient, remainder, div_by_zero);
    end
    checks++; if (alu_req !== 1'b0 || alu_a !== 0 || alu_b !== 0 || alu_signal !== 0 || alu_inv !== 0) begin
      errors++; $display("FAIL reset_alu: got req=%b a=%0h b=%0h sig=%0d inv=%b expected all 0",
                         alu_req, alu_a, alu_b, alu_signal, alu_inv);
    end
    start = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_start_ignored: got busy=%b expected 0", busy); end
    start = 1'b0; rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int cyc, den;
    run_div(32'd100, 32'd7, 1'b0, cyc, den);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL basic_timeout: got done=%b expected 1", done); end
    checks++; if (quotient !== 32'd14 || remainder !== 32'd2 || div_by_zero !== 1'b0) begin
      errors++; $display("FAIL basic_result: got q=%0d r=%0d dbz=%b expected 14 2 0", quotient, remainder, div_by_zero);
    end
    checks++; if (cyc < 65 || cyc > 97 || cyc != model_cycles(32'd100, 32'd7)) begin
      errors++; $display("FAIL basic_latency: got %0d expected %0d", cyc, model_cycles(32'd100, 32'd7));
    end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_pulse: got done=%b busy=%b expected 0 0", done, busy); end
    repeat (3) @(negedge clk);
    checks++; if (quotient !== 32'd14 || remainder !== 32'd2) begin
      errors++; $display("FAIL basic_hold: got q=%0d r=%0d expected 14 2", quotient, remainder);
    end
  endtask

  task automatic test_rem_c;
    int cyc, den;
    run_div(32'hFFFF_FFFF, 32'h8000_0001, 1'b0, cyc, den);
    checks++; if (done !== 1'b1 || quotient !== 32'd1 || remainder !== 32'h7FFF_FFFE) begin
      errors++; $display("FAIL rem_c_result: got done=%b q=%0h r=%0h expected 1 1 7ffffffe", done, quotient, remainder);
    end
    checks++; if (cyc != model_cycles(32'hFFFF_FFFF, 32'h8000_0001)) begin
      errors++; $display("FAIL rem_c_latency: got %0d expected %0d", cyc, model_cycles(32'hFFFF_FFFF, 32'h8000_0001));
    end
  endtask

  task automatic test_div_zero;
    int cyc, den;
    run_div(32'd12345, 32'd0, 1'b0, cyc, den);
    checks++; if (cyc != 1 || done !== 1'b1) begin errors++; $display("FAIL dbz_latency: got %0d expected 1", cyc); end
    checks++; if (div_by_zero !== 1'b1 || quotient !== 32'hFFFF_FFFF || remainder !== 32'd12345) begin
      errors++; $display("FAIL dbz_result: got dbz=%b q=%0h r=%0d expected 1 ffffffff 12345", div_by_zero, quotient, remainder);
    end
    run_div(32'd20, 32'd4, 1'b0, cyc, den);
    checks++; if (div_by_zero !== 1'b0 || quotient !== 32'd5 || remainder !== 32'd0) begin
      errors++; $display("FAIL dbz_clear: got dbz=%b q=%0d r=%0d expected 0 5 0", div_by_zero, quotient, remainder);
    end
  endtask

  task automatic test_gnt_stall;
    int cyc, stall_bad;
    logic [31:0] sa, sb, sq, sr;
    logic [2:0] ss;
    logic si;
    @(negedge clk);
    dividend = 32'd1000; divisor = 32'd3; start = 1'b1; alu_gnt = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    repeat (12) begin @(negedge clk); cyc++; end
    while (!alu_req && cyc < 400) begin @(negedge clk); cyc++; end
    alu_gnt = 1'b0;
    sa = alu_a; sb = alu_b; ss = alu_signal; si = alu_inv; sq = quotient; sr = remainder;
    stall_bad = 0;
    repeat (10) begin
      @(negedge clk); cyc++;
      if (!alu_req || alu_a !== sa || alu_b !== sb || alu_signal !== ss || alu_inv !== si ||
          quotient !== sq || remainder !== sr || !busy || done) stall_bad++;
    end
    checks++; if (stall_bad != 0) begin errors++; $display("FAIL stall_frozen: got %0d changed cycles expected 0", stall_bad); end
    alu_gnt = 1'b1;
    while (!done && cyc < 400) begin @(negedge clk); cyc++; end
    checks++; if (done !== 1'b1 || quotient !== 32'd333 || remainder !== 32'd1) begin
      errors++; $display("FAIL stall_result: got done=%b q=%0d r=%0d expected 1 333 1", done, quotient, remainder);
    end
    checks++; if (cyc != model_cycles(32'd1000, 32'd3) + 10) begin
      errors++; $display("FAIL stall_latency: got %0d expected %0d", cyc, model_cycles(32'd1000, 32'd3) + 10);
    end
  endtask

  task automatic test_start_busy;
    int cyc, d0;
    @(negedge clk);
    d0 = done_seen;
    dividend = 32'd100; divisor = 32'd7; start = 1'b1; alu_gnt = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    repeat (5) begin @(negedge clk); cyc++; end
    dividend = 32'd5; divisor = 32'd1; start = 1'b1;
    @(negedge clk); cyc++;
    start = 1'b0;
    while (!done && cyc < 400) begin @(negedge clk); cyc++; end
    checks++; if (done !== 1'b1 || quotient !== 32'd14 || remainder !== 32'd2) begin
      errors++; $display("FAIL busy_start_result: got done=%b q=%0d r=%0d expected 1 14 2", done, quotient, remainder);
    end
    dividend = 32'd9; divisor = 32'd3; start = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fin_start_ignored: got busy=%b expected 0", busy); end
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (done_seen - d0 != 1) begin errors++; $display("FAIL busy_start_pulses: got %0d expected 1", done_seen - d0); end
  endtask

  task automatic test_reset_mid;
    int cyc, den, d0;
    @(negedge clk);
    dividend = 32'd1000; divisor = 32'd3; start = 1'b1; alu_gnt = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    d0 = done_seen;
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || quotient !== 0 || remainder !== 0 || alu_req !== 1'b0) begin
      errors++; $display("FAIL reset_mid_outputs: got busy=%b done=%b q=%0d r=%0d req=%b expected all 0",
                         busy, done, quotient, remainder, alu_req);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (done_seen != d0) begin errors++; $display("FAIL reset_mid_no_done: got %0d pulses expected 0", done_seen - d0); end
    run_div(32'd9, 32'd3, 1'b0, cyc, den);
    checks++; if (done !== 1'b1 || quotient !== 32'd3 || remainder !== 32'd0) begin
      errors++; $display("FAIL reset_mid_restart: got done=%b q=%0d r=%0d expected 1 3 0", done, quotient, remainder);
    end
  endtask

  task automatic test_random;
    int cyc, den;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 4))
        0: b = $urandom_range(1, 15);
        1: b = 32'd0;
        2: b = a >> $urandom_range(0, 31);
        3: b = $urandom | 32'h8000_0000;
        default: b = $urandom;
      endcase
      run_div(a, b, 1'b1, cyc, den);
      checks++; if (done !== 1'b1 || quotient !== model_q(a, b) || remainder !== model_r(a, b) ||
                    div_by_zero !== (b == 32'd0)) begin
        errors++; $display("FAIL random_result %0h/%0h: got q=%0h r=%0h dbz=%b expected %0h %0h %b",
                           a, b, quotient, remainder, div_by_zero, model_q(a, b), model_r(a, b), (b == 32'd0));
      end
      checks++; if (cyc != model_cycles(a, b) + den) begin
        errors++; $display("FAIL random_latency %0h/%0h: got %0d expected %0d", a, b, cyc, model_cycles(a, b) + den);
      end
    end
    checks++; if (idle_bad != 0) begin errors++; $display("FAIL alu_idle_zero: got %0d bad cycles expected 0", idle_bad); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_rem_c;
    test_div_zero;
    test_gnt_stall;
    test_start_busy;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
